// File: rtl/ddma_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// ddma_tx_scheduler_if
// Memory-write and DDMA-command bus between the transmit scheduler (master)
// and the tile memory / DDMA engine (slave).
//   mem_enable_o, mem_wb_o       memory enable and write strobe
//   mem_addr_o, mem_data_o       memory address and write data
//   ddma_addr_o, ddma_nbytes_o   DDMA source address and byte count
//   ddma_cmd_o                   one-cycle DDMA start pulse
//   ddma_done_i                  DDMA completion pulse (slave -> master)
// ---------------------------------------------------------------------------
interface ddma_tx_scheduler_if #(
  parameter int ADDR_W = 32
);
  logic              mem_enable_o;
  logic              mem_wb_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;
  logic [ADDR_W-1:0] ddma_addr_o;
  logic [15:0]       ddma_nbytes_o;
  logic              ddma_cmd_o;
  logic              ddma_done_i;

  modport master (
    output mem_enable_o, mem_wb_o, mem_addr_o, mem_data_o,
    output ddma_addr_o, ddma_nbytes_o, ddma_cmd_o,
    input  ddma_done_i
  );

  modport slave (
    input  mem_enable_o, mem_wb_o, mem_addr_o, mem_data_o,
    input  ddma_addr_o, ddma_nbytes_o, ddma_cmd_o,
    output ddma_done_i
  );
endinterface

// File: rtl/ddma_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ddma_tx_scheduler
// Round-robin transmit sequencer for the shared DDMA engine. For each granted
// requester it writes the header flit (BASE_ADDR) and size flit (BASE_ADDR+4)
// into packet memory, issues the DDMA command, then waits for completion
// before the next grant. Zero-length requests are acked and completed with
// no memory or DDMA activity.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   req_valid_i         per-requester level request, held until acked
//   req_tx_i, req_ty_i  target X / Y per requester (8 bits per slot)
//   req_nbytes_i        payload bytes per requester (16 bits per slot)
//   req_ack_o           one-cycle one-hot acceptance pulse
//   bus                 memory / DDMA bus (ddma_tx_scheduler_if.master)
//   busy_o              high from grant until completion
//   grant_id_o          index of the current or last granted requester
//   done_o              one-cycle completion pulse
//   err_o               sticky watchdog error flag
//
// Optional feature: define DDMA_SCHED_TIMEOUT_EN to enable the WAIT-state
// watchdog (TIMEOUT_CYCLES); otherwise WAIT holds indefinitely and err_o = 0.
//
// All outputs are registered: the ack appears the cycle after the request is
// sampled in IDLE, followed by header write, size write and DDMA command on
// consecutive cycles (ack to command = 3 cycles).
// ---------------------------------------------------------------------------
module ddma_tx_scheduler #(
  parameter int                N_REQ          = 4,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 65536
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid_i,
  input  logic [N_REQ*8-1:0]    req_tx_i,
  input  logic [N_REQ*8-1:0]    req_ty_i,
  input  logic [N_REQ*16-1:0]   req_nbytes_i,
  output logic [N_REQ-1:0]      req_ack_o,
  ddma_tx_scheduler_if.master   bus,
  output logic                  busy_o,
  output logic [2:0]            grant_id_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_HDR  = 3'd1;
  localparam logic [2:0] S_WR_SIZE = 3'd2;
  localparam logic [2:0] S_CMD     = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]        state_q;
  logic [IDX_W-1:0]  rr_q;
  logic [7:0]        tx_q, ty_q;
  logic [15:0]       nb_q;
  logic [N_REQ-1:0]  ack_q;
  logic              busy_q, done_q;
  logic [2:0]        grant_q;
  logic              mem_en_q, mem_wb_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;
  logic [ADDR_W-1:0] ddma_addr_q;
  logic [15:0]       ddma_nb_q;
  logic              ddma_cmd_q;

`ifdef DDMA_SCHED_TIMEOUT_EN
  logic [31:0]       to_cnt_q;
  logic              err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Round-robin pick: first valid requester at or above rr_q, wrapping.
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] rr_d;

  always_comb begin
    logic [IDX_W:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
      if (!pick_found && req_valid_i[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    rr_d = pick_idx + 1'b1;
    if (pick_idx == IDX_W'(N_REQ - 1)) rr_d = '0;
  end

  // Size flit: word count computed in 17 bits so 16'hFFFF does not wrap.
  logic [16:0] flits;
  logic [16:0] nb_plus_hdr;
  logic [15:0] nb_sat;

  always_comb begin
    flits       = ({1'b0, nb_q} + 17'd3) >> 2;
    nb_plus_hdr = {1'b0, nb_q} + 17'd8;
    nb_sat      = nb_plus_hdr[16] ? 16'hFFFF : nb_plus_hdr[15:0];
  end

  logic [15:0] pick_nb;
  assign pick_nb = req_nbytes_i[16*pick_idx +: 16];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      nb_q        <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      grant_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_wb_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      ddma_addr_q <= '0;
      ddma_nb_q   <= '0;
      ddma_cmd_q  <= 1'b0;
`ifdef DDMA_SCHED_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q      <= '0;
      done_q     <= 1'b0;
      ddma_cmd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            ack_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            grant_q <= 3'(pick_idx);
            busy_q  <= 1'b1;
            rr_q    <= rr_d;
            tx_q    <= req_tx_i[8*pick_idx +: 8];
            ty_q    <= req_ty_i[8*pick_idx +: 8];
            nb_q    <= pick_nb;
            // Zero-length packets skip straight to completion.
            state_q <= (pick_nb == 16'd0) ? S_FIN : S_WR_HDR;
          end
        end
        S_WR_HDR: begin
          mem_en_q   <= 1'b1;
          mem_wb_q   <= 1'b1;
          mem_addr_q <= BASE_ADDR;
          mem_data_q <= {16'h0, tx_q, ty_q};
          state_q    <= S_WR_SIZE;
        end
        S_WR_SIZE: begin
          mem_addr_q <= BASE_ADDR + ADDR_W'(4);
          mem_data_q <= {15'd0, flits};
          state_q    <= S_CMD;
        end
        S_CMD: begin
          mem_en_q    <= 1'b0;
          mem_wb_q    <= 1'b0;
          ddma_addr_q <= BASE_ADDR;
          ddma_nb_q   <= nb_sat;
          ddma_cmd_q  <= 1'b1;
`ifdef DDMA_SCHED_TIMEOUT_EN
          to_cnt_q    <= '0;
`endif
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ddma_done_i) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
`ifdef DDMA_SCHED_TIMEOUT_EN
          else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
`endif
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack_o         = ack_q;
  assign busy_o            = busy_q;
  assign grant_id_o        = grant_q;
  assign done_o            = done_q;
  assign bus.mem_enable_o  = mem_en_q;
  assign bus.mem_wb_o      = mem_wb_q;
  assign bus.mem_addr_o    = mem_addr_q;
  assign bus.mem_data_o    = mem_data_q;
  assign bus.ddma_addr_o   = ddma_addr_q;
  assign bus.ddma_nbytes_o = ddma_nb_q;
  assign bus.ddma_cmd_o    = ddma_cmd_q;
`ifdef DDMA_SCHED_TIMEOUT_EN
  assign err_o             = err_q;
`else
  assign err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_ddma_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ddma_tx_scheduler
// Directed and randomized checks of ddma_tx_scheduler against a transaction
// level reference: round-robin choice from a pointer, header/size flit
// values, saturated DDMA byte count and cycle positions of each step.
// ---------------------------------------------------------------------------
module tb_ddma_tx_scheduler;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*8-1:0]  req_tx, req_ty;
  logic [N*16-1:0] req_nb;
  logic [N-1:0]    ack;
  logic            busy, done, err;
  logic [2:0]      gid;

  ddma_tx_scheduler_if #(.ADDR_W(AW)) bus ();

  ddma_tx_scheduler #(
    .N_REQ(N), .ADDR_W(AW), .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_tx_i(req_tx), .req_ty_i(req_ty),
    .req_nbytes_i(req_nb), .req_ack_o(ack), .bus(bus),
    .busy_o(busy), .grant_id_o(gid), .done_o(done), .err_o(err)
  );

  always #5 clock = ~clock;

  int   n_vec = 0;
  int   n_err = 0;
  int   model_rr;
  logic exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int ref_pick(input logic [N-1:0] v, input int rr);
    for (int o = 0; o < N; o++) begin
      if (v[(rr + o) % N]) return (rr + o) % N;
    end
    return -1;
  endfunction

  task automatic set_slot(input int k, input logic [7:0] tx, input logic [7:0] ty,
                          input logic [15:0] nb);
    req_tx[8*k +: 8]  = tx;
    req_ty[8*k +: 8]  = ty;
    req_nb[16*k +: 16] = nb;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    bus.ddma_done_i = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gid", gid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mem", {bus.mem_enable_o, bus.mem_wb_o, bus.ddma_cmd_o}, 0);
    reset = 1'b0;
    model_rr = 0;
    exp_err = 1'b0;
  endtask

  // One complete transaction for whichever requester the reference picks.
  task automatic serve(input int dly, input bit spur, input bit drop, output int lat);
    int k, e_nb;
    logic [7:0]  etx, ety;
    logic [15:0] enb;
    bit seen;
    k = ref_pick(req_valid, model_rr);
    etx = req_tx[8*k +: 8];
    ety = req_ty[8*k +: 8];
    enb = req_nb[16*k +: 16];
    e_nb = (int'(enb) + 8 > 65535) ? 65535 : int'(enb) + 8;
    seen = 0;
    lat = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clock);
      lat++;
      if (ack != 0) seen = 1;
    end
    chk("ack_seen", seen, 1);
    if (!seen) return;
    chk("ack_onehot", ack, 64'(1) << k);
    chk("ack_gid", gid, k);
    chk("ack_busy", busy, 1);
    chk("ack_done_low", done, 0);
    model_rr = (k + 1) % N;
    if (drop) req_valid[k] = 1'b0;
    if (spur) bus.ddma_done_i = 1'b1;
    if (enb == 0) begin
      @(negedge clock);
      bus.ddma_done_i = 1'b0;
      chk("z_done", done, 1);
      chk("z_busy", busy, 0);
      chk("z_wb", bus.mem_wb_o, 0);
      chk("z_cmd", bus.ddma_cmd_o, 0);
      chk("z_ack", ack, 0);
      return;
    end
    @(negedge clock);
    bus.ddma_done_i = 1'b0;
    chk("hdr_en_wb", {bus.mem_enable_o, bus.mem_wb_o}, 2'b11);
    chk("hdr_addr", bus.mem_addr_o, 0);
    chk("hdr_data", bus.mem_data_o, {16'h0, etx, ety});
    chk("hdr_ack", ack, 0);
    chk("hdr_done", done, 0);
    @(negedge clock);
    chk("size_en_wb", {bus.mem_enable_o, bus.mem_wb_o}, 2'b11);
    chk("size_addr", bus.mem_addr_o, 4);
    chk("size_data", bus.mem_data_o, (int'(enb) + 3) / 4);
    @(negedge clock);
    chk("cmd_pulse", bus.ddma_cmd_o, 1);
    chk("cmd_en_wb", {bus.mem_enable_o, bus.mem_wb_o}, 0);
    chk("cmd_addr", bus.ddma_addr_o, 0);
    chk("cmd_nbytes", bus.ddma_nbytes_o, e_nb);
    for (int w = 1; w < dly; w++) begin
      @(negedge clock);
      chk("wait_cmd", bus.ddma_cmd_o, 0);
      chk("wait_busy_done", {busy, done}, 2'b10);
      chk("wait_nbytes", bus.ddma_nbytes_o, e_nb);
    end
    bus.ddma_done_i = 1'b1;
    @(negedge clock);
    bus.ddma_done_i = 1'b0;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_gid", gid, k);
    chk("fin_err", err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    req_tx = '0; req_ty = '0; req_nb = '0;
    do_reset();

    // Basic transaction on requester 0.
    set_slot(0, 8'd2, 8'd1, 16'd8192);
    req_valid = 4'b0001;
    serve(4, 0, 1, lat);
    chk("first_ack_cycle", lat, 1);

    // All requesters held: round-robin order 0,1,2,3,0, one ack per grant.
    do_reset();
    for (int k = 0; k < N; k++) set_slot(k, 8'(k + 16), 8'(k + 32), 16'(100 * (k + 1)));
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      chk("rr_order_ref", ref_pick(req_valid, model_rr), t % N);
      serve(10, 0, 0, lat);
    end
    req_valid = '0;

    // nbytes 5 then 0.
    set_slot(2, 8'hA5, 8'h5A, 16'd5);
    req_valid = 4'b0100;
    serve(3, 0, 1, lat);
    set_slot(2, 8'h11, 8'h22, 16'd0);
    req_valid = 4'b0100;
    serve(3, 0, 1, lat);

    // Spurious done in IDLE, then during WR_HDR.
    @(negedge clock);
    bus.ddma_done_i = 1'b1;
    @(negedge clock);
    bus.ddma_done_i = 1'b0;
    chk("spur_idle_done", done, 0);
    chk("spur_idle_busy", busy, 0);
    set_slot(1, 8'h33, 8'h44, 16'd64);
    req_valid = 4'b0010;
    serve(2, 1, 1, lat);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < N; k++) begin
        int sel;
        logic [15:0] nb;
        sel = $urandom_range(0, 5);
        nb = (sel == 0) ? 16'd0 : (sel == 1) ? 16'hFFFF : (sel == 2) ? 16'd65530
             : 16'($urandom_range(1, 3000));
        set_slot(k, 8'($urandom), 8'($urandom), nb);
      end
      req_valid = 4'($urandom_range(1, 15));
      serve($urandom_range(1, 5), $urandom_range(0, 1), $urandom_range(0, 1), lat);
    end
    req_valid = '0;

    // Reset asserted while waiting for DDMA completion.
    set_slot(3, 8'h01, 8'h02, 16'd40);
    req_valid = 4'b1000;
    lat = 0;
    while (ack == 0 && lat < 8) begin @(negedge clock); lat++; end
    chk("rstw_ack", ack, 4'b1000);
    repeat (3) @(negedge clock);
    chk("rstw_cmd", bus.ddma_cmd_o, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_busy_done", {busy, done, err}, 0);
    chk("rstw_ack0", ack, 0);
    chk("rstw_gid", gid, 0);
    chk("rstw_bus", {bus.mem_enable_o, bus.mem_wb_o, bus.ddma_cmd_o,
                     bus.ddma_nbytes_o, bus.mem_data_o[15:0]}, 0);
    req_valid = '0;
    @(negedge clock);
    chk("rstw_no_done", done, 0);
    reset = 1'b0;
    model_rr = 0;
    exp_err = 1'b0;
    @(negedge clock);
    chk("rstw_after_done", done, 0);
    set_slot(1, 8'h0F, 8'hF0, 16'd12);
    req_valid = 4'b0010;
    serve(2, 0, 1, lat);

`ifdef DDMA_SCHED_TIMEOUT_EN
    // Watchdog: no completion ever returned.
    do_reset();
    set_slot(0, 8'h09, 8'h08, 16'd16);
    req_valid = 4'b0001;
    lat = 0;
    while (ack == 0 && lat < 8) begin @(negedge clock); lat++; end
    chk("to_ack", ack, 4'b0001);
    req_valid = '0;
    model_rr = 1;
    repeat (3) @(negedge clock);
    chk("to_cmd", bus.ddma_cmd_o, 1);
    for (int c = 1; c < TO; c++) begin
      @(negedge clock);
      chk("to_wait_done_err", {done, err}, 0);
    end
    @(negedge clock);
    chk("to_done_err", {done, err}, 2'b11);
    chk("to_busy", busy, 0);
    exp_err = 1'b1;
    set_slot(2, 8'h07, 8'h06, 16'd20);
    req_valid = 4'b0100;
    serve(3, 0, 1, lat);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
